// File: rtl/sub8_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub8_serial_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub8_serial_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface sub8_serial_if
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             Flag_Carry;
  logic             Flag_Zero;
  logic             Flag_Overflow;
  logic             Flag_Negative;

  modport master (
    output start, operand_1, operand_2,
    input  busy, done, diff, Flag_Carry, Flag_Zero, Flag_Overflow, Flag_Negative
  );

  modport slave (
    input  start, operand_1, operand_2,
    output busy, done, diff, Flag_Carry, Flag_Zero, Flag_Overflow, Flag_Negative
  );

endinterface

// File: rtl/sub8_serial_full_adder1.sv
// Single-bit full adder; the only arithmetic cell of the serial datapath.
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial operand_1 - operand_2 (LSB first, as a + ~b + 1) with C/Z/V/N flags.
// One bit per clock; outputs are registered and only change on the completion edge.
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sub8_serial_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cim_q, cim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             fc_q, fc_d;
  logic             fz_q, fz_d;
  logic             fv_q, fv_d;
  logic             fn_q, fn_d;

  logic fa_s;
  logic fa_cout;

  // The subtrahend is inverted bit by bit; the +1 comes from the carry preset to 1.
  full_adder1 u_fa (
    .a    (a_q[0]),
    .b    (~b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state logic for the FSM, datapath shift registers and output registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cim_d   = cim_q;
    diff_d  = diff_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    fv_d    = fv_q;
    fn_d    = fn_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.operand_1;
          b_d     = bus.operand_2;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        // Carry into the sign bit is needed for the signed-overflow flag.
        if (cnt_q == PRE_MSB) begin
          cim_d = fa_cout;
        end
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = res_d;
          fc_d    = fa_cout;
          fv_d    = cim_q ^ fa_cout;
          fz_d    = (res_d == '0);
          fn_d    = res_d[WIDTH-1] ^ (cim_q ^ fa_cout);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Register everything; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cim_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fv_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cim_q   <= cim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      fv_q    <= fv_d;
      fn_q    <= fn_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.diff          = diff_q;
  assign bus.Flag_Carry    = fc_q;
  assign bus.Flag_Zero     = fz_q;
  assign bus.Flag_Overflow = fv_q;
  assign bus.Flag_Negative = fn_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Self-checking bench for sub8_serial: directed table, control corner cases, random vs model.
module tb_sub8_serial;
  import sub8_serial_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  logic clk = 1'b0;
  logic rst;

  sub8_serial_if #(.WIDTH(W)) bus ();

  sub8_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic [3:0] czvn;
  } vec_t;

  vec_t tbl[5];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical difference.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, sd;
    logic [7:0] d;
    logic c, z, v, n;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    d  = 8'((ua - ub) & 255);
    c  = (ua >= ub);
    z  = (d == 8'h00);
    v  = (sd > 127) || (sd < -128);
    n  = (sd < 0);
    return {d, c, z, v, n};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.Flag_Carry, bus.Flag_Zero, bus.Flag_Overflow, bus.Flag_Negative};
  endfunction

  // Accept one operation, optionally re-pulse start mid-RUN, wait for done.
  // lat = number of edges after the accept edge until done is seen, -1 on timeout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int pulse_at, output int lat);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operand_1 = a;
    bus.operand_2 = b;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_1 = ~a;
    bus.operand_2 = a ^ b;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == pulse_at) begin
        bus.start     = 1'b1;
        bus.operand_1 = 8'h10;
        bus.operand_2 = 8'h20;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  // Full transaction with checks of result, flags, latency and return to IDLE.
  task automatic run_checked(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] ed, input logic [3:0] ef, input int pulse_at);
    int lat;
    do_op(a, b, pulse_at, lat);
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " diff"}, 32'(bus.diff), 32'(ed));
    check({tag, " CZVN"}, 32'(dut_flags()), 32'(ef));
    @(negedge clk);
    check({tag, " done drop"}, 32'({bus.done, bus.busy}), 32'(0));
    check({tag, " diff hold"}, 32'(bus.diff), 32'(ed));
    $display("op %s: 0x%02h - 0x%02h -> diff 0x%02h CZVN %04b latency %0d",
             tag, a, b, bus.diff, dut_flags(), lat);
  endtask

  initial begin
    int         saw_done;
    logic [7:0] ra, rb;
    logic [11:0] m;

    tbl[0] = '{a: 8'h64, b: 8'h31, diff: 8'h33, czvn: 4'b1000};
    tbl[1] = '{a: 8'hFE, b: 8'hFF, diff: 8'hFF, czvn: 4'b0001};
    tbl[2] = '{a: 8'h7F, b: 8'h80, diff: 8'hFF, czvn: 4'b0010};
    tbl[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, czvn: 4'b1011};
    tbl[4] = '{a: 8'h5A, b: 8'h5A, diff: 8'h00, czvn: 4'b1100};

    bus.start     = 1'b0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy/done", 32'({bus.busy, bus.done}), 32'(0));
    check("reset diff", 32'(bus.diff), 32'(0));
    check("reset flags", 32'(dut_flags()), 32'(0));
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_checked($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].czvn, 0);
    end

    // Busy check on the first cycle after accept.
    @(negedge clk);
    bus.start = 1'b1; bus.operand_1 = 8'h01; bus.operand_2 = 8'h02;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy after accept", 32'({bus.busy, bus.done}), 32'(2));
    check("diff held into next op", 32'(bus.diff), 32'(8'h00));
    saw_done = 0;
    for (int i = 0; i < 20 && saw_done == 0; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("second op done", 32'(saw_done), 32'(1));
    check("second op diff", 32'(bus.diff), 32'(8'hFF));
    @(negedge clk);

    // Start pulsed during RUN is dropped.
    run_checked("start-in-run", 8'h64, 8'h31, 8'h33, 4'b1000, 3);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1;
    end
    check("lost request idle", 32'(saw_done), 32'(0));

    // Reset while bit 3 is being processed.
    @(negedge clk);
    bus.start = 1'b1; bus.operand_1 = 8'hFE; bus.operand_2 = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun rst busy/done", 32'({bus.busy, bus.done}), 32'(0));
    check("midrun rst diff", 32'(bus.diff), 32'(0));
    check("midrun rst flags", 32'(dut_flags()), 32'(0));
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("no done after abort", 32'(saw_done), 32'(0));
    $display("op abort: reset mid-RUN, done seen %0d", saw_done);

    // Randomized against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? ra : 8'($urandom_range(0, 255));
      m  = model(ra, rb);
      run_checked($sformatf("rnd%0d", i), ra, rb, m[11:4], m[3:0], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
